// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter in front of one 36-bit port of a true-dual-port block RAM.
// Define BRAM_ARB_CLEAR_EN to sweep CLEAR_VALUE through the whole memory after reset.
module bram_port_arbiter #(
  parameter int          FIXED_PRIO  = 0,
  parameter logic [35:0] CLEAR_VALUE = 36'h0
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        REQ0,
  input  logic        WE0,
  input  logic [3:0]  BE0,
  input  logic [9:0]  ADDR0,
  input  logic [35:0] WDATA0,
  input  logic        REQ1,
  input  logic        WE1,
  input  logic [3:0]  BE1,
  input  logic [9:0]  ADDR1,
  input  logic [35:0] WDATA1,
  output logic        GNT0,
  output logic        GNT1,
  output logic        RVALID0,
  output logic [35:0] RDATA0,
  output logic        RVALID1,
  output logic [35:0] RDATA1,
  output logic        RAM_WEN,
  output logic        RAM_REN,
  output logic [3:0]  RAM_BE,
  output logic [14:0] RAM_ADDR,
  output logic [31:0] RAM_WDATA,
  output logic [3:0]  RAM_WPARITY,
  input  logic [31:0] RAM_RDATA,
  input  logic [3:0]  RAM_RPARITY,
  output logic        BUSY
);

  logic        arbActive;
  logic        gnt0, gnt1;
  logic        last_q;
  logic        cmdValid_q, cmdWe_q, cmdTag_q;
  logic [3:0]  cmdBe_q;
  logic [9:0]  cmdAddr_q;
  logic [35:0] cmdWdata_q;
  logic        cmdWe_d;
  logic [3:0]  cmdBe_d;
  logic [9:0]  cmdAddr_d;
  logic [35:0] cmdWdata_d;
  logic        rvalid0_q, rvalid1_q;

`ifdef BRAM_ARB_CLEAR_EN
  typedef enum logic {CLEAR, ARB} state_e;
  state_e     state_q;
  logic [9:0] clearAddr_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= CLEAR;
      clearAddr_q <= '0;
    end else if (state_q == CLEAR) begin
      clearAddr_q <= clearAddr_q + 10'd1;
      if (clearAddr_q == 10'h3FF) state_q <= ARB;
    end
  end

  // Gated by reset so nothing is written or reported busy while reset is held.
  assign BUSY      = RESET_N && (state_q == CLEAR);
  assign arbActive = RESET_N && (state_q == ARB);
`else
  assign BUSY      = 1'b0;
  assign arbActive = RESET_N;
`endif

  // On a tie the grant goes to whichever requester was not served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (arbActive) begin
      if (FIXED_PRIO != 0) gnt0 = REQ0;
      else                 gnt0 = REQ0 && (!REQ1 || last_q);
      gnt1 = REQ1 && !gnt0;
    end
  end

  assign GNT0 = gnt0;
  assign GNT1 = gnt1;

  assign cmdWe_d    = gnt1 ? WE1    : WE0;
  assign cmdBe_d    = gnt1 ? BE1    : BE0;
  assign cmdAddr_d  = gnt1 ? ADDR1  : ADDR0;
  assign cmdWdata_d = gnt1 ? WDATA1 : WDATA0;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      last_q     <= 1'b1;
      cmdValid_q <= 1'b0;
      cmdWe_q    <= 1'b0;
      cmdTag_q   <= 1'b0;
      cmdBe_q    <= '0;
      cmdAddr_q  <= '0;
      cmdWdata_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      cmdValid_q <= gnt0 || gnt1;
      if (gnt0 || gnt1) begin
        last_q     <= gnt1;
        cmdTag_q   <= gnt1;
        cmdWe_q    <= cmdWe_d;
        cmdBe_q    <= cmdBe_d;
        cmdAddr_q  <= cmdAddr_d;
        cmdWdata_q <= cmdWdata_d;
      end
      rvalid0_q <= cmdValid_q && !cmdWe_q && !cmdTag_q;
      rvalid1_q <= cmdValid_q && !cmdWe_q &&  cmdTag_q;
    end
  end

  // The RAM port sees either the registered command or a clear-sweep write, never both.
  always_comb begin
    RAM_WEN     = 1'b0;
    RAM_REN     = 1'b0;
    RAM_BE      = '0;
    RAM_ADDR    = '0;
    RAM_WDATA   = '0;
    RAM_WPARITY = '0;
    if (cmdValid_q) begin
      RAM_WEN                  = cmdWe_q;
      RAM_REN                  = !cmdWe_q;
      RAM_BE                   = cmdBe_q;
      RAM_ADDR                 = {cmdAddr_q, 5'b0};
      {RAM_WPARITY, RAM_WDATA} = cmdWdata_q;
    end
`ifdef BRAM_ARB_CLEAR_EN
    if (BUSY) begin
      RAM_WEN                  = 1'b1;
      RAM_BE                   = 4'hF;
      RAM_ADDR                 = {clearAddr_q, 5'b0};
      {RAM_WPARITY, RAM_WDATA} = CLEAR_VALUE;
    end
`endif
  end

  assign RVALID0 = rvalid0_q;
  assign RVALID1 = rvalid1_q;
  assign RDATA0  = rvalid0_q ? {RAM_RPARITY, RAM_RDATA} : 36'h0;
  assign RDATA1  = rvalid1_q ? {RAM_RPARITY, RAM_RDATA} : 36'h0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: a round-robin instance backed by a RAM model,
// plus a fixed-priority instance whose grants are compared on shared stimulus.
module tb_bram_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        REQ0 = 1'b0, WE0 = 1'b0, REQ1 = 1'b0, WE1 = 1'b0;
  logic [3:0]  BE0 = '0, BE1 = '0;
  logic [9:0]  ADDR0 = '0, ADDR1 = '0;
  logic [35:0] WDATA0 = '0, WDATA1 = '0;

  logic        GNT0, GNT1, RVALID0, RVALID1, BUSY;
  logic [35:0] RDATA0, RDATA1;
  logic        RAM_WEN, RAM_REN;
  logic [3:0]  RAM_BE, RAM_WPARITY;
  logic [14:0] RAM_ADDR;
  logic [31:0] RAM_WDATA;

  logic        fpGnt0, fpGnt1, fpRvalid0, fpRvalid1, fpBusy;
  logic [35:0] fpRdata0, fpRdata1;
  logic        fpRamWen, fpRamRen;
  logic [3:0]  fpRamBe, fpRamWparity;
  logic [14:0] fpRamAddr;
  logic [31:0] fpRamWdata;

  logic [35:0] mem [1024];
  logic [35:0] rdQ;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  bram_port_arbiter #(.FIXED_PRIO(0), .CLEAR_VALUE(36'h0)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ0(REQ0), .WE0(WE0), .BE0(BE0), .ADDR0(ADDR0), .WDATA0(WDATA0),
    .REQ1(REQ1), .WE1(WE1), .BE1(BE1), .ADDR1(ADDR1), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1),
    .RVALID0(RVALID0), .RDATA0(RDATA0), .RVALID1(RVALID1), .RDATA1(RDATA1),
    .RAM_WEN(RAM_WEN), .RAM_REN(RAM_REN), .RAM_BE(RAM_BE), .RAM_ADDR(RAM_ADDR),
    .RAM_WDATA(RAM_WDATA), .RAM_WPARITY(RAM_WPARITY),
    .RAM_RDATA(rdQ[31:0]), .RAM_RPARITY(rdQ[35:32]),
    .BUSY(BUSY)
  );

  bram_port_arbiter #(.FIXED_PRIO(1), .CLEAR_VALUE(36'h0)) dutFp (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ0(REQ0), .WE0(WE0), .BE0(BE0), .ADDR0(ADDR0), .WDATA0(WDATA0),
    .REQ1(REQ1), .WE1(WE1), .BE1(BE1), .ADDR1(ADDR1), .WDATA1(WDATA1),
    .GNT0(fpGnt0), .GNT1(fpGnt1),
    .RVALID0(fpRvalid0), .RDATA0(fpRdata0), .RVALID1(fpRvalid1), .RDATA1(fpRdata1),
    .RAM_WEN(fpRamWen), .RAM_REN(fpRamRen), .RAM_BE(fpRamBe), .RAM_ADDR(fpRamAddr),
    .RAM_WDATA(fpRamWdata), .RAM_WPARITY(fpRamWparity),
    .RAM_RDATA(32'h0), .RAM_RPARITY(4'h0),
    .BUSY(fpBusy)
  );

  // Single-port RAM model with one cycle of read latency and per-byte write enables.
  always @(posedge CLK) begin
    if (RAM_WEN) begin
      for (int k = 0; k < 4; k++) begin
        if (RAM_BE[k]) begin
          mem[RAM_ADDR[14:5]][8*k +: 8] <= RAM_WDATA[8*k +: 8];
          mem[RAM_ADDR[14:5]][32+k]     <= RAM_WPARITY[k];
        end
      end
    end
    if (RAM_REN) rdQ <= mem[RAM_ADDR[14:5]];
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(
    input logic r0, input logic w0, input logic [3:0] b0, input logic [9:0] a0, input logic [35:0] d0,
    input logic r1, input logic w1, input logic [3:0] b1, input logic [9:0] a1, input logic [35:0] d1);
    @(posedge CLK);
    #1;
    REQ0 = r0; WE0 = w0; BE0 = b0; ADDR0 = a0; WDATA0 = d0;
    REQ1 = r1; WE1 = w1; BE1 = b1; ADDR1 = a1; WDATA1 = d1;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 4'h0, 10'h0, 36'h0, 0, 0, 4'h0, 10'h0, 36'h0);
  endtask

  task automatic runClear(output int busyCycles, output int goodWrites, output int earlyGrants);
    busyCycles  = 0;
    goodWrites  = 0;
    earlyGrants = 0;
    for (int i = 0; i < 2000 && BUSY === 1'b1; i++) begin
      if (RAM_WEN === 1'b1 && RAM_BE === 4'hF && RAM_ADDR === {busyCycles[9:0], 5'b0} &&
          {RAM_WPARITY, RAM_WDATA} === 36'h0)
        goodWrites++;
      if (GNT0 !== 1'b0 || GNT1 !== 1'b0) earlyGrants++;
      busyCycles++;
      @(posedge CLK);
      #2;
    end
  endtask

  initial begin
    logic [5:0] rrPattern;
    int busyCycles, goodWrites, earlyGrants;
    rrPattern = 6'b010101;

    RESET_N = 1'b0;
    REQ0 = 1'b1;
    REQ1 = 1'b1;
    repeat (2) @(posedge CLK);
    #2;
    checkOutput("rst_gnt0", GNT0, 0);
    checkOutput("rst_gnt1", GNT1, 0);
    checkOutput("rst_fp_gnt0", fpGnt0, 0);
    checkOutput("rst_rvalid0", RVALID0, 0);
    checkOutput("rst_rdata0", RDATA0, 0);
    checkOutput("rst_ram_wen", RAM_WEN, 0);
    checkOutput("rst_ram_ren", RAM_REN, 0);
    checkOutput("rst_ram_be", RAM_BE, 0);
    checkOutput("rst_ram_addr", RAM_ADDR, 0);
    checkOutput("rst_busy", BUSY, 0);

    @(posedge CLK);
    #1;
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    RESET_N = 1'b1;
    #1;
`ifdef BRAM_ARB_CLEAR_EN
    runClear(busyCycles, goodWrites, earlyGrants);
    checkOutput("clear_busy_cycles", busyCycles, 1024);
    checkOutput("clear_writes", goodWrites, 1024);
`else
    checkOutput("busy_idle", BUSY, 0);
`endif

    // Both requesters held: round-robin alternates, fixed priority always favours 0.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, 4'hF, 10'h010, 36'h1_00000010, 1, 1, 4'hF, 10'h011, 36'h2_00000011);
      checkOutput($sformatf("rr_gnt0_%0d", i), GNT0, rrPattern[i]);
      checkOutput($sformatf("rr_gnt1_%0d", i), GNT1, !rrPattern[i]);
      checkOutput($sformatf("fp_gnt0_%0d", i), fpGnt0, 1);
      checkOutput($sformatf("fp_gnt1_%0d", i), fpGnt1, 0);
    end

    applyStimulus(1, 1, 4'hF, 10'h005, 36'h5_12345678, 0, 0, 4'h0, 10'h0, 36'h0);
    checkOutput("wr5_gnt0", GNT0, 1);
    checkOutput("pipe_r1_wen", RAM_WEN, 1);
    checkOutput("pipe_r1_addr", RAM_ADDR, 15'h0220);
    checkOutput("pipe_r1_wdata", {RAM_WPARITY, RAM_WDATA}, 36'h2_00000011);

    applyStimulus(1, 0, 4'hF, 10'h005, 36'h0, 0, 0, 4'h0, 10'h0, 36'h0);
    checkOutput("rd5_gnt0", GNT0, 1);
    checkOutput("wr5_ram_wen", RAM_WEN, 1);
    checkOutput("wr5_ram_be", RAM_BE, 4'hF);
    checkOutput("wr5_ram_addr", RAM_ADDR, 15'h00A0);
    checkOutput("wr5_ram_wdata", RAM_WDATA, 32'h12345678);
    checkOutput("wr5_ram_wparity", RAM_WPARITY, 4'h5);

    idleCycle();
    checkOutput("rd5_ram_ren", RAM_REN, 1);
    checkOutput("rd5_ram_wen", RAM_WEN, 0);
    checkOutput("rd5_ram_addr", RAM_ADDR, 15'h00A0);
    checkOutput("rd5_early_rvalid", RVALID0, 0);

    idleCycle();
    checkOutput("rd5_rvalid0", RVALID0, 1);
    checkOutput("rd5_rdata0", RDATA0, 36'h5_12345678);
    checkOutput("rd5_rvalid1", RVALID1, 0);
    checkOutput("rd5_rdata1", RDATA1, 0);

    idleCycle();
    checkOutput("idle_rvalid0", RVALID0, 0);
    checkOutput("idle_rdata0", RDATA0, 0);
    checkOutput("idle_ram_ren", RAM_REN, 0);
    checkOutput("idle_ram_wen", RAM_WEN, 0);
    checkOutput("idle_ram_addr", RAM_ADDR, 0);
    checkOutput("idle_ram_be", RAM_BE, 0);

    // Requester 1 writes the top word, requester 0 reads it on the very next grant.
    applyStimulus(0, 0, 4'h0, 10'h0, 36'h0, 1, 1, 4'hF, 10'h3FF, 36'h9_DEADBEEF);
    checkOutput("raw_gnt1", GNT1, 1);
    checkOutput("raw_gnt0_idle", GNT0, 0);
    applyStimulus(1, 0, 4'hF, 10'h3FF, 36'h0, 0, 0, 4'h0, 10'h0, 36'h0);
    checkOutput("raw_gnt0", GNT0, 1);
    idleCycle();
    checkOutput("raw_ram_addr", RAM_ADDR, 15'h7FE0);
    idleCycle();
    checkOutput("raw_rvalid0", RVALID0, 1);
    checkOutput("raw_rdata0", RDATA0, 36'h9_DEADBEEF);

    applyStimulus(1, 1, 4'b0101, 10'h3FF, 36'hA_11223344, 0, 0, 4'h0, 10'h0, 36'h0);
    checkOutput("be_gnt0", GNT0, 1);
    applyStimulus(0, 0, 4'h0, 10'h0, 36'h0, 1, 0, 4'hF, 10'h3FF, 36'h0);
    checkOutput("be_gnt1", GNT1, 1);
    idleCycle();
    idleCycle();
    checkOutput("be_rvalid1", RVALID1, 1);
    checkOutput("be_rvalid0", RVALID0, 0);
    checkOutput("be_rdata1", RDATA1, 36'h8_DE22BE44);

    // Back-to-back reads from both requesters come back in grant order.
    applyStimulus(1, 0, 4'hF, 10'h005, 36'h0, 1, 0, 4'hF, 10'h3FF, 36'h0);
    checkOutput("b2b_gnt0", GNT0, 1);
    checkOutput("b2b_gnt1_wait", GNT1, 0);
    applyStimulus(0, 0, 4'h0, 10'h0, 36'h0, 1, 0, 4'hF, 10'h3FF, 36'h0);
    checkOutput("b2b_gnt1", GNT1, 1);
    idleCycle();
    checkOutput("b2b_first_rvalid0", RVALID0, 1);
    checkOutput("b2b_first_rvalid1", RVALID1, 0);
    checkOutput("b2b_first_rdata0", RDATA0, 36'h5_12345678);
    idleCycle();
    checkOutput("b2b_second_rvalid1", RVALID1, 1);
    checkOutput("b2b_second_rvalid0", RVALID0, 0);
    checkOutput("b2b_second_rdata1", RDATA1, 36'h8_DE22BE44);

    // Reset lands while a read is in flight: the return must never appear.
    applyStimulus(1, 0, 4'hF, 10'h005, 36'h0, 0, 0, 4'h0, 10'h0, 36'h0);
    checkOutput("abort_gnt0", GNT0, 1);
    @(posedge CLK);
    #1;
    REQ0 = 1'b0;
    RESET_N = 1'b0;
    #1;
    checkOutput("abort_ram_ren", RAM_REN, 0);
    checkOutput("abort_ram_addr", RAM_ADDR, 0);
    checkOutput("abort_rvalid_t1", RVALID0, 0);
    @(posedge CLK);
    #2;
    checkOutput("abort_rvalid_t2", RVALID0, 0);
    checkOutput("abort_rdata_t2", RDATA0, 0);
    checkOutput("abort_busy", BUSY, 0);
    @(posedge CLK);
    #1;
`ifdef BRAM_ARB_CLEAR_EN
    REQ0 = 1'b1; WE0 = 1'b0; BE0 = 4'hF; ADDR0 = 10'h123;
`endif
    RESET_N = 1'b1;
    #1;
`ifdef BRAM_ARB_CLEAR_EN
    runClear(busyCycles, goodWrites, earlyGrants);
    checkOutput("reclear_busy_cycles", busyCycles, 1024);
    checkOutput("reclear_writes", goodWrites, 1024);
    checkOutput("reclear_no_grant", earlyGrants, 0);
    checkOutput("reclear_first_gnt0", GNT0, 1);
    idleCycle();
    idleCycle();
    checkOutput("cleared_rvalid0", RVALID0, 1);
    checkOutput("cleared_rdata0", RDATA0, 36'h0);
`else
    checkOutput("abort_rvalid_after", RVALID0, 0);
    idleCycle();
    checkOutput("abort_rvalid_late", RVALID0, 0);
    applyStimulus(1, 0, 4'hF, 10'h005, 36'h0, 0, 0, 4'h0, 10'h0, 36'h0);
    checkOutput("post_rst_gnt0", GNT0, 1);
    idleCycle();
    idleCycle();
    checkOutput("post_rst_rvalid0", RVALID0, 1);
    checkOutput("post_rst_rdata0", RDATA0, 36'h5_12345678);
`endif

    $display("[TB] directed sequence complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
